// File: rtl/morse_pkg.sv
// Shared Morse definitions for the RX decoder and the TX encoder.
// - Letter index constants (A=0..Z=25) and the empty display slot code.
// - Symbol storage types and the receiver FSM state enum.
// - letter_code(): the single letter -> (sym_bits, sym_len) table.
//   Symbols are stored LSB-first (bit 0 is the first symbol); dot=0, dash=1.
package morse_pkg;

  localparam int MAX_SYMS = 4;

  localparam logic [4:0] CHAR_EMPTY = 5'd31;
  localparam logic [4:0] CHAR_A = 5'd0,  CHAR_B = 5'd1,  CHAR_C = 5'd2,  CHAR_D = 5'd3;
  localparam logic [4:0] CHAR_E = 5'd4,  CHAR_F = 5'd5,  CHAR_G = 5'd6,  CHAR_H = 5'd7;
  localparam logic [4:0] CHAR_I = 5'd8,  CHAR_J = 5'd9,  CHAR_K = 5'd10, CHAR_L = 5'd11;
  localparam logic [4:0] CHAR_M = 5'd12, CHAR_N = 5'd13, CHAR_O = 5'd14, CHAR_P = 5'd15;
  localparam logic [4:0] CHAR_Q = 5'd16, CHAR_R = 5'd17, CHAR_S = 5'd18, CHAR_T = 5'd19;
  localparam logic [4:0] CHAR_U = 5'd20, CHAR_V = 5'd21, CHAR_W = 5'd22, CHAR_X = 5'd23;
  localparam logic [4:0] CHAR_Y = 5'd24, CHAR_Z = 5'd25;

  typedef logic [2:0]          sym_len_t;
  typedef logic [MAX_SYMS-1:0] sym_bits_t;

  typedef enum logic [1:0] {IDLE, MARK, SPACE} rx_state_e;

  typedef struct packed {
    sym_bits_t bits;
    sym_len_t  len;
  } morse_code_t;

  // Bits above len are always zero in this table.
  function automatic morse_code_t letter_code(input logic [4:0] idx);
    morse_code_t c;
    c = '{bits: 4'b0000, len: 3'd0};
    case (idx)
      CHAR_A: c = '{bits: 4'b0010, len: 3'd2};  // .-
      CHAR_B: c = '{bits: 4'b0001, len: 3'd4};  // -...
      CHAR_C: c = '{bits: 4'b0101, len: 3'd4};  // -.-.
      CHAR_D: c = '{bits: 4'b0001, len: 3'd3};  // -..
      CHAR_E: c = '{bits: 4'b0000, len: 3'd1};  // .
      CHAR_F: c = '{bits: 4'b0100, len: 3'd4};  // ..-.
      CHAR_G: c = '{bits: 4'b0011, len: 3'd3};  // --.
      CHAR_H: c = '{bits: 4'b0000, len: 3'd4};  // ....
      CHAR_I: c = '{bits: 4'b0000, len: 3'd2};  // ..
      CHAR_J: c = '{bits: 4'b1110, len: 3'd4};  // .---
      CHAR_K: c = '{bits: 4'b0101, len: 3'd3};  // -.-
      CHAR_L: c = '{bits: 4'b0010, len: 3'd4};  // .-..
      CHAR_M: c = '{bits: 4'b0011, len: 3'd2};  // --
      CHAR_N: c = '{bits: 4'b0001, len: 3'd2};  // -.
      CHAR_O: c = '{bits: 4'b0111, len: 3'd3};  // ---
      CHAR_P: c = '{bits: 4'b0110, len: 3'd4};  // .--.
      CHAR_Q: c = '{bits: 4'b1011, len: 3'd4};  // --.-
      CHAR_R: c = '{bits: 4'b0010, len: 3'd3};  // .-.
      CHAR_S: c = '{bits: 4'b0000, len: 3'd3};  // ...
      CHAR_T: c = '{bits: 4'b0001, len: 3'd1};  // -
      CHAR_U: c = '{bits: 4'b0100, len: 3'd3};  // ..-
      CHAR_V: c = '{bits: 4'b1000, len: 3'd4};  // ...-
      CHAR_W: c = '{bits: 4'b0110, len: 3'd3};  // .--
      CHAR_X: c = '{bits: 4'b1001, len: 3'd4};  // -..-
      CHAR_Y: c = '{bits: 4'b1101, len: 3'd4};  // -.--
      CHAR_Z: c = '{bits: 4'b0011, len: 3'd4};  // --..
      default: c = '{bits: 4'b0000, len: 3'd0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/morse_sym_decode.sv
// Combinational symbol-group decoder.
// - sym_bits_i / sym_len_i : collected symbols, LSB-first, dot=0 dash=1
// - idx_o                  : letter index (0 when not valid)
// - valid_o                : group matches a letter; length 0 and unused
//                            length-4 patterns are never valid
module morse_sym_decode
  import morse_pkg::*;
(
  input  sym_bits_t  sym_bits_i,
  input  sym_len_t   sym_len_i,
  output logic [4:0] idx_o,
  output logic       valid_o
);

  sym_bits_t mask;
  assign mask = sym_bits_t'((5'd1 << sym_len_i) - 5'd1);

  always_comb begin
    morse_code_t code;
    code    = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < 26; i++) begin
      code = letter_code(5'(i));
      if (code.len == sym_len_i && code.bits == (sym_bits_i & mask)) begin
        idx_o   = 5'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_rx_decoder.sv
// Morse receiver: samples iLine on half-second ticks, classifies mark
// runs as dot/dash and space runs as symbol/letter gaps, decodes each
// letter and shifts it into an 8-slot display buffer.
// - iCLK, iRST_n     : clock, synchronous active-low reset
// - iEnable          : low forces IDLE and drops the partial letter
// - iLine            : Morse line (1 = mark), used only on tick cycles
// - iHalfSec         : free-running counter; any change is one tick
// - iClear           : level; empties the display buffer
// - oCharValid/oErr  : 1-cycle pulses for a pushed / discarded letter
// - oCharIdx         : last decoded letter index
// - oDisplayData     : newest letter in [4:0], empty slot = 31
// - oBusy            : receiver in MARK or SPACE
module morse_rx_decoder
  import morse_pkg::*;
#(
  parameter int BUF_CHARS      = 8,
  parameter int DOT_TICKS      = 1,
  parameter int DASH_TICKS     = 3,
  parameter int CHAR_GAP_TICKS = 3
) (
  input  logic                   iCLK,
  input  logic                   iRST_n,
  input  logic                   iEnable,
  input  logic                   iLine,
  input  logic [3:0]             iHalfSec,
  input  logic                   iClear,
  output logic                   oCharValid,
  output logic [4:0]             oCharIdx,
  output logic [5*BUF_CHARS-1:0] oDisplayData,
  output logic                   oErr,
  output logic                   oBusy
);

  localparam int DW = 5 * BUF_CHARS;
  localparam logic [DW-1:0] DISP_EMPTY = {BUF_CHARS{CHAR_EMPTY}};

  logic [3:0]    half_q;
  rx_state_e     state_q, state_d;
  logic [2:0]    mark_q, mark_d, space_q, space_d;
  sym_bits_t     bits_q, bits_d;
  sym_len_t      len_q, len_d;
  logic          bad_q, bad_d;
  logic [DW-1:0] disp_q, disp_d;
  logic [4:0]    idx_q, idx_d;
  logic          valid_q, valid_d, err_q, err_d, busy_q;

  logic       tick;
  logic [4:0] dec_idx;
  logic       dec_ok;

  assign tick = (iHalfSec != half_q);

  morse_sym_decode u_dec (
    .sym_bits_i (bits_q),
    .sym_len_i  (len_q),
    .idx_o      (dec_idx),
    .valid_o    (dec_ok)
  );

  always_comb begin
    state_d = state_q;
    mark_d  = mark_q;
    space_d = space_q;
    bits_d  = bits_q;
    len_d   = len_q;
    bad_d   = bad_q;
    disp_d  = disp_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (!iEnable) begin
      // Silent abort: no oErr for a letter cut off by disable.
      state_d = IDLE;
      mark_d  = '0;
      space_d = '0;
      bits_d  = '0;
      len_d   = '0;
      bad_d   = 1'b0;
    end else if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (iLine) begin
            state_d = MARK;
            mark_d  = 3'd1;
          end
        end
        MARK: begin
          if (iLine) begin
            if (mark_q != 3'd7) mark_d = mark_q + 3'd1;
          end else begin
            if (len_q == sym_len_t'(MAX_SYMS) ||
                (mark_q != 3'(DOT_TICKS) && mark_q != 3'(DASH_TICKS))) begin
              bad_d = 1'b1;
            end else begin
              bits_d[len_q[1:0]] = (mark_q == 3'(DASH_TICKS));
              len_d              = len_q + 3'd1;
            end
            state_d = SPACE;
            mark_d  = '0;
            space_d = 3'd1;
          end
        end
        SPACE: begin
          if (iLine) begin
            state_d = MARK;
            mark_d  = 3'd1;
            space_d = '0;
          end else if (space_q + 3'd1 == 3'(CHAR_GAP_TICKS)) begin
            // Letter gap reached: decode what was collected and restart.
            if (!bad_q && dec_ok) begin
              disp_d  = {disp_q[DW-6:0], dec_idx};
              idx_d   = dec_idx;
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            state_d = IDLE;
            space_d = '0;
            bits_d  = '0;
            len_d   = '0;
            bad_d   = 1'b0;
          end else begin
            space_d = space_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Clear overrides a same-cycle push; the pulse and index still go out.
    if (iClear) disp_d = DISP_EMPTY;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      half_q  <= '0;
      state_q <= IDLE;
      mark_q  <= '0;
      space_q <= '0;
      bits_q  <= '0;
      len_q   <= '0;
      bad_q   <= 1'b0;
      disp_q  <= DISP_EMPTY;
      idx_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      half_q  <= iHalfSec;
      state_q <= state_d;
      mark_q  <= mark_d;
      space_q <= space_d;
      bits_q  <= bits_d;
      len_q   <= len_d;
      bad_q   <= bad_d;
      disp_q  <= disp_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign oCharValid   = valid_q;
  assign oCharIdx     = idx_q;
  assign oDisplayData = disp_q;
  assign oErr         = err_q;
  assign oBusy        = busy_q;

endmodule

// File: tb/tb_morse_rx_decoder.sv
module tb_morse_rx_decoder;

  logic        iCLK = 1'b0;
  logic        iRST_n, iEnable, iLine, iClear;
  logic [3:0]  iHalfSec;
  logic        oCharValid, oErr, oBusy;
  logic [4:0]  oCharIdx;
  logic [39:0] oDisplayData;

  localparam logic [39:0] EMPTY = {8{5'd31}};

  int errs = 0;
  int checks = 0;
  int vcnt = 0;
  int ecnt = 0;
  logic [4:0] vq[$];

  string morse_tab[9] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", ".."};

  morse_rx_decoder dut (
    .iCLK         (iCLK),
    .iRST_n       (iRST_n),
    .iEnable      (iEnable),
    .iLine        (iLine),
    .iHalfSec     (iHalfSec),
    .iClear       (iClear),
    .oCharValid   (oCharValid),
    .oCharIdx     (oCharIdx),
    .oDisplayData (oDisplayData),
    .oErr         (oErr),
    .oBusy        (oBusy)
  );

  always #5 iCLK = ~iCLK;

  // Pulse recorder.
  always @(negedge iCLK) begin
    if (oCharValid) begin
      vcnt++;
      vq.push_back(oCharIdx);
    end
    if (oErr) ecnt++;
  end

  task automatic clr_mon();
    vcnt = 0;
    ecnt = 0;
    vq.delete();
  endtask

  task automatic send_tick(input bit l);
    repeat (2) @(negedge iCLK);
    iLine    = l;
    iHalfSec = iHalfSec + 4'd1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_tick(s[i] == 8'h31);
  endtask

  function automatic string frame(input string m);
    string s;
    s = "";
    for (int i = 0; i < m.len(); i++) begin
      if (i > 0) s = {s, "0"};
      s = {s, (m[i] == 8'h2D) ? "111" : "1"};
    end
    return {s, "000"};
  endfunction

  task automatic settle();
    repeat (3) @(negedge iCLK);
  endtask

  task automatic clear_buf();
    @(negedge iCLK); iClear = 1'b1;
    @(negedge iCLK); iClear = 1'b0;
  endtask

  task automatic test_reset();
    iRST_n = 1'b0; iEnable = 1'b1; iLine = 1'b0; iHalfSec = 4'd5; iClear = 1'b0;
    repeat (3) @(negedge iCLK);
    checks++; if (oDisplayData !== EMPTY) begin errs++; $display("FAIL reset_disp got=%h exp=%h", oDisplayData, EMPTY); end
    checks++; if (oCharIdx !== 5'd0) begin errs++; $display("FAIL reset_idx got=%0d exp=0", oCharIdx); end
    checks++; if ({oCharValid, oErr, oBusy} !== 3'b000) begin errs++; $display("FAIL reset_pulses got=%b exp=000", {oCharValid, oErr, oBusy}); end
    iRST_n = 1'b1;
    settle();
  endtask

  task automatic test_letter_a();
    clr_mon();
    send_tick(1'b1);
    @(negedge iCLK);
    checks++; if (oBusy !== 1'b1) begin errs++; $display("FAIL a_busy got=%b exp=1", oBusy); end
    send_str("0111000");
    settle();
    checks++; if (vcnt != 1 || vq.size() != 1) begin errs++; $display("FAIL a_count got=%0d exp=1", vcnt); end
    else begin checks++; if (vq[0] !== 5'd0) begin errs++; $display("FAIL a_idx got=%0d exp=0", vq[0]); end end
    checks++; if (oDisplayData !== {{7{5'd31}}, 5'd0}) begin errs++; $display("FAIL a_disp got=%h", oDisplayData); end
    checks++; if (oBusy !== 1'b0 || ecnt != 0) begin errs++; $display("FAIL a_idle busy=%b err=%0d exp 0/0", oBusy, ecnt); end
  endtask

  task automatic test_sos();
    clear_buf();
    clr_mon();
    send_str("101010001110111011100010101000");
    settle();
    checks++; if (vcnt != 3 || vq.size() != 3) begin errs++; $display("FAIL sos_count got=%0d exp=3", vcnt); end
    else begin
      checks++; if ({vq[0], vq[1], vq[2]} !== {5'd18, 5'd14, 5'd18}) begin errs++; $display("FAIL sos_idx got=%0d,%0d,%0d exp=18,14,18", vq[0], vq[1], vq[2]); end
    end
    checks++; if (oDisplayData !== {{5{5'd31}}, 5'd18, 5'd14, 5'd18}) begin errs++; $display("FAIL sos_disp got=%h", oDisplayData); end
  endtask

  task automatic test_errors();
    logic [39:0] exp;
    clear_buf();
    send_str("10111000");
    settle();
    exp = {{7{5'd31}}, 5'd0};
    clr_mon();
    send_str("11000");
    settle();
    checks++; if (ecnt != 1 || vcnt != 0) begin errs++; $display("FAIL err_run2 err=%0d val=%0d exp 1/0", ecnt, vcnt); end
    checks++; if (oDisplayData !== exp) begin errs++; $display("FAIL err_run2_disp got=%h exp=%h", oDisplayData, exp); end
    clr_mon();
    send_str(frame("..--"));
    settle();
    checks++; if (ecnt != 1 || vcnt != 0 || oDisplayData !== exp) begin errs++; $display("FAIL err_unused err=%0d val=%0d disp=%h", ecnt, vcnt, oDisplayData); end
    clr_mon();
    send_str(frame("--.-"));
    settle();
    checks++; if (vcnt != 1 || oCharIdx !== 5'd16 || ecnt != 0) begin errs++; $display("FAIL q_decode val=%0d idx=%0d exp 1/16", vcnt, oCharIdx); end
    checks++; if (oDisplayData !== {{6{5'd31}}, 5'd0, 5'd16}) begin errs++; $display("FAIL q_disp got=%h", oDisplayData); end
  endtask

  task automatic test_wrap();
    clear_buf();
    clr_mon();
    for (int i = 0; i < 9; i++) send_str(frame(morse_tab[i]));
    settle();
    checks++; if (vcnt != 9 || ecnt != 0) begin errs++; $display("FAIL wrap_count val=%0d err=%0d exp 9/0", vcnt, ecnt); end
    checks++; if (oDisplayData !== {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8}) begin errs++; $display("FAIL wrap_disp got=%h", oDisplayData); end
  endtask

  task automatic test_clear_push();
    clr_mon();
    send_str("100");
    repeat (2) @(negedge iCLK);
    iLine = 1'b0; iHalfSec = iHalfSec + 4'd1; iClear = 1'b1;
    @(negedge iCLK); iClear = 1'b0;
    settle();
    checks++; if (vcnt != 1 || oCharIdx !== 5'd4) begin errs++; $display("FAIL clr_push val=%0d idx=%0d exp 1/4", vcnt, oCharIdx); end
    checks++; if (oDisplayData !== EMPTY) begin errs++; $display("FAIL clr_push_disp got=%h exp=%h", oDisplayData, EMPTY); end
  endtask

  task automatic test_abort();
    clr_mon();
    send_str("1011");
    @(negedge iCLK); iRST_n = 1'b0; iLine = 1'b0;
    repeat (2) @(negedge iCLK); iRST_n = 1'b1;
    @(negedge iCLK);
    checks++; if (oBusy !== 1'b0) begin errs++; $display("FAIL rst_busy got=%b exp=0", oBusy); end
    send_str(frame("."));
    settle();
    checks++; if (vcnt != 1 || ecnt != 0 || oDisplayData !== {{7{5'd31}}, 5'd4}) begin errs++; $display("FAIL rst_mid val=%0d err=%0d disp=%h", vcnt, ecnt, oDisplayData); end
    clr_mon();
    send_str("1011");
    @(negedge iCLK); iEnable = 1'b0; iLine = 1'b0;
    repeat (2) @(negedge iCLK); iEnable = 1'b1;
    @(negedge iCLK);
    checks++; if (oBusy !== 1'b0) begin errs++; $display("FAIL en_busy got=%b exp=0", oBusy); end
    send_str(frame("."));
    settle();
    checks++; if (vcnt != 1 || ecnt != 0 || oDisplayData !== {{6{5'd31}}, 5'd4, 5'd4}) begin errs++; $display("FAIL en_mid val=%0d err=%0d disp=%h", vcnt, ecnt, oDisplayData); end
  endtask

  task automatic test_no_tick();
    int drops;
    drops = 0;
    clr_mon();
    send_tick(1'b1);
    @(negedge iCLK);
    for (int i = 0; i < 100; i++) begin
      @(negedge iCLK);
      iLine = ~iLine;
      if (oBusy !== 1'b1) drops++;
    end
    checks++; if (drops != 0 || vcnt != 0 || ecnt != 0) begin errs++; $display("FAIL notick drops=%0d val=%0d err=%0d exp 0", drops, vcnt, ecnt); end
    send_str("000");
    settle();
    checks++; if (vcnt != 1 || oCharIdx !== 5'd4) begin errs++; $display("FAIL notick_dot val=%0d idx=%0d exp 1/4", vcnt, oCharIdx); end
  endtask

  initial begin
    test_reset();
    test_letter_a();
    test_sos();
    test_errors();
    test_wrap();
    test_clear_push();
    test_abort();
    test_no_tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
